// File: rtl/ptp_pkg.sv
// Shared definitions for the PTP slave timestamp-exchange sequencer:
// FSM state codes, PTP messageType constants and the default phase timeout.
package ptp_pkg;

   // Exchange FSM state codes (also exported on the state output)
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_FUP  = 3'd1;
   localparam logic [2:0] ST_TX_REQ    = 3'd2;
   localparam logic [2:0] ST_TX_WAIT   = 3'd3;
   localparam logic [2:0] ST_WAIT_RESP = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

   // PTP messageType words as seen by the parser / frame builder
   localparam logic [15:0] MSG_SYNC       = 16'h8002;
   localparam logic [15:0] MSG_FOLLOW_UP  = 16'h8802;
   localparam logic [15:0] MSG_DELAY_RESP = 16'h8902;
   localparam logic [15:0] MSG_DELAY_REQ  = 16'h8102;

   // 100 ms at 250 MHz
   localparam int unsigned TIMEOUT_CYC_DEF = 25_000_000;

endpackage

// File: rtl/ptp_exchange_ctrl_if.sv
// Event, handshake and status bundle between the PTP parser / TX builder
// (master side) and the exchange sequencer (slave side).
interface ptp_exchange_ctrl_if;
   logic        enable;
   logic        sync_vld;
   logic        fup_vld;
   logic        resp_vld;
   logic [15:0] resp_seqid;
   logic        tx_ack;
   logic        tx_done;
   logic        tx_req;
   logic [15:0] seq_id;
   logic        cap_t2;
   logic        cap_t1;
   logic        cap_t3;
   logic        cap_t4;
   logic        calc_start;
   logic        busy;
   logic [2:0]  state;
   logic [7:0]  timeout_cnt;
   logic [7:0]  mismatch_cnt;

   modport master (
      output enable, sync_vld, fup_vld, resp_vld, resp_seqid, tx_ack, tx_done,
      input  tx_req, seq_id, cap_t2, cap_t1, cap_t3, cap_t4, calc_start,
             busy, state, timeout_cnt, mismatch_cnt
   );

   modport slave (
      input  enable, sync_vld, fup_vld, resp_vld, resp_seqid, tx_ack, tx_done,
      output tx_req, seq_id, cap_t2, cap_t1, cap_t3, cap_t4, calc_start,
             busy, state, timeout_cnt, mismatch_cnt
   );
endinterface

// File: rtl/ptp_timeout_cnt.sv
// Phase watchdog: up-counter cleared on phase entry, counting while the
// phase is active, flagging expire on the last allowed cycle.
module ptp_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYC = 25_000_000,
   parameter int          TO_W        = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] count;

   // Clear has priority; hold at the terminal value so it can never wrap
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && !expire) begin
         count <= count + 1'b1;
      end
   end

   assign expire = en && (count == LAST);

endmodule

// File: rtl/ptp_exchange_ctrl.sv
// PTP slave exchange sequencer: walks Sync -> Follow_Up -> Delay_Req TX ->
// Delay_Resp, strobing t2/t1/t3/t4 captures and firing calc_start once a
// consistent set exists. All outputs are registered.
module ptp_exchange_ctrl
   import ptp_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int          TO_W        = 25
) (
   input  logic                eth_rx_clk_250m,
   input  logic                rst,
   ptp_exchange_ctrl_if.slave  bus
);

   logic [2:0]  state_reg, state_nxt;
   logic [15:0] seq_reg;
   logic        tx_req_reg, busy_reg;
   logic        t2_reg, t1_reg, t3_reg, t4_reg, calc_reg;
   logic        t2_nxt, t1_nxt, t3_nxt, t4_nxt, calc_nxt;
   logic [7:0]  to_cnt_reg, mm_cnt_reg;
   logic        seq_inc, to_inc, mm_inc;
   logic        to_clr, to_en, to_expire;
   logic        resp_match;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign resp_match = bus.resp_vld && (bus.resp_seqid == seq_reg);
   assign to_en      = (state_reg == ST_WAIT_FUP) || (state_reg == ST_WAIT_RESP);

   ptp_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) u_timeout (
      .clk    (eth_rx_clk_250m),
      .rst    (rst),
      .clr    (to_clr),
      .en     (to_en),
      .expire (to_expire)
   );

   // Next-state and strobe decode; events always beat a coincident timeout
   always_comb begin
      state_nxt = state_reg;
      t2_nxt    = 1'b0;
      t1_nxt    = 1'b0;
      t3_nxt    = 1'b0;
      t4_nxt    = 1'b0;
      calc_nxt  = 1'b0;
      seq_inc   = 1'b0;
      to_inc    = 1'b0;
      mm_inc    = 1'b0;
      to_clr    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.sync_vld && bus.enable) begin
               state_nxt = ST_WAIT_FUP;
               t2_nxt    = 1'b1;
               to_clr    = 1'b1;
            end
         end
         ST_WAIT_FUP: begin
            if (!bus.enable) begin
               state_nxt = ST_IDLE;
            end else if (bus.sync_vld) begin
               // A newer Sync supersedes the pending one, even alongside a Follow_Up
               t2_nxt = 1'b1;
               to_clr = 1'b1;
            end else if (bus.fup_vld) begin
               state_nxt = ST_TX_REQ;
               t1_nxt    = 1'b1;
               seq_inc   = 1'b1;
            end else if (to_expire) begin
               state_nxt = ST_IDLE;
               to_inc    = 1'b1;
            end
         end
         ST_TX_REQ: begin
            // tx_req is already high for the whole of this state
            if (bus.tx_ack && tx_req_reg) begin
               state_nxt = ST_TX_WAIT;
               t3_nxt    = 1'b1;
            end
         end
         ST_TX_WAIT: begin
            if (bus.tx_done) begin
               state_nxt = ST_WAIT_RESP;
               to_clr    = 1'b1;
            end
         end
         ST_WAIT_RESP: begin
            if (!bus.enable) begin
               state_nxt = ST_IDLE;
            end else begin
               mm_inc = bus.resp_vld && !resp_match;
               if (resp_match) begin
                  state_nxt = ST_DONE;
                  t4_nxt    = 1'b1;
               end else if (bus.sync_vld) begin
                  state_nxt = ST_WAIT_FUP;
                  t2_nxt    = 1'b1;
                  to_clr    = 1'b1;
               end else if (to_expire) begin
                  state_nxt = ST_IDLE;
                  to_inc    = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            calc_nxt  = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, request and busy registers; tx_req mirrors residency in TX_REQ
   always_ff @(posedge eth_rx_clk_250m) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         tx_req_reg <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_nxt;
         tx_req_reg <= (state_nxt == ST_TX_REQ);
         busy_reg   <= (state_nxt != ST_IDLE);
      end
   end

   // One-cycle capture and calc strobes
   always_ff @(posedge eth_rx_clk_250m) begin
      if (rst) begin
         t2_reg   <= 1'b0;
         t1_reg   <= 1'b0;
         t3_reg   <= 1'b0;
         t4_reg   <= 1'b0;
         calc_reg <= 1'b0;
      end else begin
         t2_reg   <= t2_nxt;
         t1_reg   <= t1_nxt;
         t3_reg   <= t3_nxt;
         t4_reg   <= t4_nxt;
         calc_reg <= calc_nxt;
      end
   end

   // Delay_Req sequenceId (wraps naturally) and saturating event counters
   always_ff @(posedge eth_rx_clk_250m) begin
      if (rst) begin
         seq_reg    <= 16'h0000;
         to_cnt_reg <= 8'd0;
         mm_cnt_reg <= 8'd0;
      end else begin
         if (seq_inc) seq_reg    <= seq_reg + 16'd1;
         if (to_inc)  to_cnt_reg <= sat_inc(to_cnt_reg);
         if (mm_inc)  mm_cnt_reg <= sat_inc(mm_cnt_reg);
      end
   end

   assign bus.tx_req       = tx_req_reg;
   assign bus.seq_id       = seq_reg;
   assign bus.cap_t2       = t2_reg;
   assign bus.cap_t1       = t1_reg;
   assign bus.cap_t3       = t3_reg;
   assign bus.cap_t4       = t4_reg;
   assign bus.calc_start   = calc_reg;
   assign bus.busy         = busy_reg;
   assign bus.state        = state_reg;
   assign bus.timeout_cnt  = to_cnt_reg;
   assign bus.mismatch_cnt = mm_cnt_reg;

endmodule

// File: tb/tb_ptp_exchange_ctrl.sv
// Self-checking bench for ptp_exchange_ctrl: vector table, directed
// multi-cycle sequences and a randomized run against a phase-level model.
module tb_ptp_exchange_ctrl;

   localparam int TO = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #2 clk = ~clk;

   ptp_exchange_ctrl_if bus();

   ptp_exchange_ctrl #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (
      .eth_rx_clk_250m (clk),
      .rst             (rst),
      .bus             (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        en, sync, fup, resp;
      logic [15:0] rid;
      logic        ack, done;
      logic [2:0]  st;
      logic [4:0]  strb;   // {calc, t4, t3, t1, t2}
      logic        req;
      logic [15:0] seq;
      logic [7:0]  mm;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] strb();
      return {bus.calc_start, bus.cap_t4, bus.cap_t3, bus.cap_t1, bus.cap_t2};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic en, input logic s, input logic f, input logic r,
                        input logic [15:0] rid, input logic a, input logic d);
      bus.enable     = en;
      bus.sync_vld   = s;
      bus.fup_vld    = f;
      bus.resp_vld   = r;
      bus.resp_seqid = rid;
      bus.tx_ack     = a;
      bus.tx_done    = d;
      tick();
      bus.sync_vld = 1'b0;
      bus.fup_vld  = 1'b0;
      bus.resp_vld = 1'b0;
      bus.tx_ack   = 1'b0;
      bus.tx_done  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic exchange(input logic [15:0] rid);
      apply(1, 1, 0, 0, 16'h0, 0, 0);
      apply(1, 0, 1, 0, 16'h0, 0, 0);
      apply(1, 0, 0, 0, 16'h0, 1, 0);
      apply(1, 0, 0, 0, 16'h0, 0, 1);
      apply(1, 0, 0, 1, rid,   0, 0);
      apply(1, 0, 0, 0, 16'h0, 0, 0);
   endtask

   // ---------------- phase-level reference model ----------------
   typedef enum int {PH_IDLE = 0, PH_FUP = 1, PH_TXREQ = 2, PH_TXWAIT = 3,
                     PH_RESP = 4, PH_DONE = 5} phase_t;
   phase_t      m_ph;
   int          m_edge, m_entry;
   logic [15:0] m_seq;
   int          m_to, m_mm;
   logic [4:0]  m_strb;

   task automatic model_reset();
      m_ph = PH_IDLE; m_edge = 0; m_entry = 0;
      m_seq = 16'h0; m_to = 0; m_mm = 0; m_strb = 5'b0;
   endtask

   task automatic model_step(input logic en, input logic s, input logic f, input logic r,
                             input logic [15:0] rid, input logic a, input logic d);
      bit timed_out;
      m_edge++;
      m_strb = 5'b0;
      timed_out = (m_edge - m_entry) == TO;
      if (m_ph == PH_IDLE) begin
         if (s && en) begin m_ph = PH_FUP; m_strb[0] = 1; m_entry = m_edge; end
      end else if (m_ph == PH_FUP) begin
         if (!en) m_ph = PH_IDLE;
         else if (s) begin m_strb[0] = 1; m_entry = m_edge; end
         else if (f) begin m_ph = PH_TXREQ; m_strb[1] = 1; m_seq = m_seq + 16'd1; end
         else if (timed_out) begin m_ph = PH_IDLE; m_to = (m_to < 255) ? m_to + 1 : 255; end
      end else if (m_ph == PH_TXREQ) begin
         if (a) begin m_ph = PH_TXWAIT; m_strb[2] = 1; end
      end else if (m_ph == PH_TXWAIT) begin
         if (d) begin m_ph = PH_RESP; m_entry = m_edge; end
      end else if (m_ph == PH_RESP) begin
         if (!en) m_ph = PH_IDLE;
         else begin
            if (r && rid != m_seq) m_mm = (m_mm < 255) ? m_mm + 1 : 255;
            if (r && rid == m_seq) begin m_ph = PH_DONE; m_strb[3] = 1; end
            else if (s) begin m_ph = PH_FUP; m_strb[0] = 1; m_entry = m_edge; end
            else if (timed_out) begin m_ph = PH_IDLE; m_to = (m_to < 255) ? m_to + 1 : 255; end
         end
      end else begin
         m_ph = PH_IDLE; m_strb[4] = 1;
      end
   endtask

   initial begin
      bus.enable = 1'b0; bus.sync_vld = 1'b0; bus.fup_vld = 1'b0; bus.resp_vld = 1'b0;
      bus.resp_seqid = 16'h0; bus.tx_ack = 1'b0; bus.tx_done = 1'b0;

      //            en sy fu re rid      ak dn   st     strb     rq seq  mm
      tbl[0]  = '{1, 1, 0, 0, 16'h0000, 0, 0, 3'd1, 5'b00001, 0, 16'd0, 8'd0};
      tbl[1]  = '{1, 0, 1, 0, 16'h0000, 0, 0, 3'd2, 5'b00010, 1, 16'd1, 8'd0};
      tbl[2]  = '{1, 0, 0, 0, 16'h0000, 1, 0, 3'd3, 5'b00100, 0, 16'd1, 8'd0};
      tbl[3]  = '{1, 0, 0, 0, 16'h0000, 0, 1, 3'd4, 5'b00000, 0, 16'd1, 8'd0};
      tbl[4]  = '{1, 0, 0, 1, 16'h0002, 0, 0, 3'd4, 5'b00000, 0, 16'd1, 8'd1};
      tbl[5]  = '{1, 0, 0, 1, 16'h0001, 0, 0, 3'd5, 5'b01000, 0, 16'd1, 8'd1};
      tbl[6]  = '{1, 0, 0, 0, 16'h0000, 0, 0, 3'd0, 5'b10000, 0, 16'd1, 8'd1};
      tbl[7]  = '{1, 1, 0, 0, 16'h0000, 0, 0, 3'd1, 5'b00001, 0, 16'd1, 8'd1};
      tbl[8]  = '{1, 1, 1, 0, 16'h0000, 0, 0, 3'd1, 5'b00001, 0, 16'd1, 8'd1};
      tbl[9]  = '{1, 0, 1, 0, 16'h0000, 0, 0, 3'd2, 5'b00010, 1, 16'd2, 8'd1};
      tbl[10] = '{0, 1, 0, 0, 16'h0000, 1, 0, 3'd3, 5'b00100, 0, 16'd2, 8'd1};
      tbl[11] = '{0, 0, 0, 0, 16'h0000, 0, 1, 3'd4, 5'b00000, 0, 16'd2, 8'd1};
      tbl[12] = '{1, 1, 0, 0, 16'h0000, 0, 0, 3'd1, 5'b00001, 0, 16'd2, 8'd1};
      tbl[13] = '{0, 0, 0, 0, 16'h0000, 0, 0, 3'd0, 5'b00000, 0, 16'd2, 8'd1};

      // ---- reset state ----
      tick(); tick();
      do_reset();
      chk("rst_state", bus.state, 0);
      chk("rst_txreq", bus.tx_req, 0);
      chk("rst_seq", bus.seq_id, 0);
      chk("rst_strobes", strb(), 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_counters", {bus.timeout_cnt, bus.mismatch_cnt}, 0);

      // ---- vector table ----
      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].en, tbl[i].sync, tbl[i].fup, tbl[i].resp, tbl[i].rid, tbl[i].ack, tbl[i].done);
         chk($sformatf("vec%0d_state", i), bus.state, tbl[i].st);
         chk($sformatf("vec%0d_strobes", i), strb(), tbl[i].strb);
         chk($sformatf("vec%0d_txreq", i), bus.tx_req, tbl[i].req);
         chk($sformatf("vec%0d_seq", i), bus.seq_id, tbl[i].seq);
         chk($sformatf("vec%0d_mm", i), bus.mismatch_cnt, tbl[i].mm);
         chk($sformatf("vec%0d_busy", i), bus.busy, tbl[i].st != 3'd0);
      end
      chk("vec_timeouts", bus.timeout_cnt, 0);

      // ---- nominal timing ----
      do_reset();
      for (int c = 0; c < 56; c++) begin
         logic [4:0] e;
         apply(1, c == 10, c == 20, c == 50, 16'h0001, c == 25, c == 40);
         e = (c == 10) ? 5'b00001 : (c == 20) ? 5'b00010 : (c == 25) ? 5'b00100 :
             (c == 50) ? 5'b01000 : (c == 51) ? 5'b10000 : 5'b00000;
         chk($sformatf("nom_strobes_c%0d", c + 1), strb(), e);
         chk($sformatf("nom_txreq_c%0d", c + 1), bus.tx_req, (c >= 20) && (c < 25));
      end
      chk("nom_seq", bus.seq_id, 16'h0001);

      // ---- minimum end-to-end latency ----
      do_reset();
      apply(1, 1, 0, 0, 16'h0, 0, 0);
      apply(1, 0, 1, 0, 16'h0, 1, 0);
      apply(1, 0, 0, 0, 16'h0, 1, 1);
      apply(1, 0, 0, 0, 16'h0, 0, 1);
      apply(1, 0, 0, 1, 16'h1, 0, 0);
      chk("min_t4", strb(), 5'b01000);
      apply(1, 0, 0, 0, 16'h0, 0, 0);
      chk("min_calc", strb(), 5'b10000);

      // ---- mismatch 0x0005 vs 0x0004 ----
      do_reset();
      exchange(16'h0001); exchange(16'h0002); exchange(16'h0003);
      apply(1, 1, 0, 0, 16'h0, 0, 0);
      apply(1, 0, 1, 0, 16'h0, 0, 0);
      chk("mm_seq", bus.seq_id, 16'h0004);
      apply(1, 0, 0, 0, 16'h0, 1, 0);
      apply(1, 0, 0, 0, 16'h0, 0, 1);
      apply(1, 0, 0, 1, 16'h0005, 0, 0);
      chk("mm_cnt", bus.mismatch_cnt, 1);
      chk("mm_no_t4", {bus.state, strb()}, {3'd4, 5'b00000});
      apply(1, 0, 0, 1, 16'h0004, 0, 0);
      chk("mm_match_t4", strb(), 5'b01000);
      apply(1, 0, 0, 0, 16'h0, 0, 0);
      chk("mm_calc", strb(), 5'b10000);

      // ---- resp match wins over simultaneous Sync ----
      apply(1, 1, 0, 0, 16'h0, 0, 0);
      apply(1, 0, 1, 0, 16'h0, 0, 0);
      apply(1, 0, 0, 0, 16'h0, 1, 0);
      apply(1, 0, 0, 0, 16'h0, 0, 1);
      apply(1, 1, 0, 1, 16'h0005, 0, 0);
      chk("prio_resp_sync", {bus.state, strb()}, {3'd5, 5'b01000});
      apply(1, 0, 0, 0, 16'h0, 0, 0);
      chk("prio_sync_dropped", {bus.state, strb()}, {3'd0, 5'b10000});

      // ---- sequenceId wrap ----
      do_reset();
      force dut.seq_reg = 16'hFFFF;
      tick();
      release dut.seq_reg;
      chk("wrap_preset", bus.seq_id, 16'hFFFF);
      apply(1, 1, 0, 0, 16'h0, 0, 0);
      apply(1, 0, 1, 0, 16'h0, 0, 0);
      chk("wrap_seq", bus.seq_id, 16'h0000);
      apply(1, 0, 0, 0, 16'h0, 1, 0);
      apply(1, 0, 0, 0, 16'h0, 0, 1);
      apply(1, 0, 0, 1, 16'h0000, 0, 0);
      chk("wrap_t4", strb(), 5'b01000);
      apply(1, 0, 0, 0, 16'h0, 0, 0);
      chk("wrap_calc", strb(), 5'b10000);

      // ---- reset mid TX_REQ ----
      do_reset();
      apply(1, 1, 0, 0, 16'h0, 0, 0);
      apply(1, 0, 1, 0, 16'h0, 0, 0);
      chk("rstmid_pre", {bus.state, bus.tx_req, bus.seq_id}, {3'd2, 1'b1, 16'h0001});
      rst = 1'b1;
      apply(1, 0, 0, 0, 16'h0, 1, 0);
      rst = 1'b0;
      chk("rstmid_post", {bus.state, bus.tx_req, bus.seq_id, strb()}, {3'd0, 1'b0, 16'h0, 5'b0});
      apply(1, 0, 0, 0, 16'h0, 1, 0);
      apply(1, 0, 0, 0, 16'h0, 0, 1);
      chk("rstmid_late", {bus.state, bus.tx_req, strb(), bus.busy}, 0);

      // ---- timeout exactly TO cycles after WAIT_FUP entry ----
      do_reset();
      apply(1, 1, 0, 0, 16'h0, 0, 0);
      for (int i = 1; i <= TO; i++) begin
         tick();
         if (i == TO - 1) chk("to_still_waiting", bus.state, 1);
         if (i == TO) chk("to_idle", {bus.state, bus.timeout_cnt}, {3'd0, 8'd1});
      end
      for (int n = 0; n < 299; n++) begin
         apply(1, 1, 0, 0, 16'h0, 0, 0);
         repeat (TO) tick();
      end
      chk("to_saturated", {bus.state, bus.timeout_cnt}, {3'd0, 8'd255});

      // ---- randomized run against the model ----
      do_reset();
      model_reset();
      for (int c = 0; c < 8000 && errors < 20; c++) begin
         logic en, s, f, r, a, d;
         logic [15:0] rid;
         en  = ($urandom_range(0, 24) != 0);
         s   = ($urandom_range(0, 39) == 0);
         f   = ($urandom_range(0, 9) == 0);
         r   = ($urandom_range(0, 7) == 0);
         rid = ($urandom_range(0, 2) != 0) ? m_seq : 16'($urandom_range(0, 7));
         a   = ($urandom_range(0, 3) == 0);
         d   = ($urandom_range(0, 4) == 0);
         model_step(en, s, f, r, rid, a, d);
         apply(en, s, f, r, rid, a, d);
         chk($sformatf("rand_c%0d", c),
             {bus.state, bus.tx_req, bus.seq_id, strb(), bus.busy, bus.timeout_cnt, bus.mismatch_cnt},
             {3'(m_ph), m_ph == PH_TXREQ, m_seq, m_strb, m_ph != PH_IDLE, 8'(m_to), 8'(m_mm)});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ptp_exchange_ctrl.md
# ptp_exchange_ctrl

Sequencer for the PTP slave's timestamp exchange, on the receive-side clock between the PTP frame parser and the TX frame builder / MAC. It consumes qualified Sync, Follow_Up and Delay_Resp event pulses, issues timestamp-capture strobes (t2, t1, t3, t4), and requests one Delay_Req transmission per Sync with a req/ack handshake. It enforces sequence-id matching and per-phase timeouts, and fires a single `calc_start` pulse only when a complete, consistent t1..t4 set exists.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 25_000_000: wait limit per phase in clock cycles (100 ms at 250 MHz).
- `TO_W`, default 25: timeout counter width; `2**TO_W` must exceed `TIMEOUT_CYC`.

Ports:
- `eth_rx_clk_250m`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: exchange enable (level).
- `sync_vld`, in, 1: one-cycle pulse, Sync parsed with clock identity OK.
- `fup_vld`, in, 1: one-cycle pulse, Follow_Up parsed with clock identity OK.
- `resp_vld`, in, 1: one-cycle pulse, Delay_Resp parsed.
- `resp_seqid`, in, 16: sequenceId of the Delay_Resp, valid with `resp_vld`.
- `tx_ack`, in, 1: TX builder accepted the request; t3 is sampled now.
- `tx_done`, in, 1: one-cycle pulse, Delay_Req fully sent.
- `tx_req`, out, 1: Delay_Req transmit request.
- `seq_id`, out, 16: sequenceId for the outgoing Delay_Req.
- `cap_t2`, `cap_t1`, `cap_t3`, `cap_t4`, out, 1 each: one-cycle capture strobes.
- `calc_start`, out, 1: one-cycle pulse, t1..t4 set complete.
- `busy`, out, 1: state is not IDLE.
- `state`, out, 3: current state encoding.
- `timeout_cnt`, out, 8: saturating count of phase timeouts.
- `mismatch_cnt`, out, 8: saturating count of Delay_Resp with a wrong sequenceId.

## Operation
- States:
  - IDLE=0
  - WAIT_FUP=1
  - TX_REQ=2
  - TX_WAIT=3
  - WAIT_RESP=4
  - DONE=5
- IDLE: `sync_vld` and `enable` → WAIT_FUP, pulse `cap_t2`.
- WAIT_FUP:
  - `fup_vld` → TX_REQ; pulse `cap_t1`; `seq_id` <= `seq_id`+1 (16-bit wrap, FFFF→0000).
  - `sync_vld` restarts: stay in WAIT_FUP, pulse `cap_t2`, reload the timeout.
- TX_REQ:
  - `tx_req`=1 until `tx_ack` is sampled high.
  - On ack → TX_WAIT, pulse `cap_t3`, `tx_req`=0.
  - No timeout. Sync and `enable` are ignored.
- TX_WAIT: `tx_done` → WAIT_RESP. No timeout. Sync and `enable` are ignored.
- WAIT_RESP:
  - `resp_vld` with `resp_seqid`==`seq_id` → DONE, pulse `cap_t4`.
  - `resp_vld` with a mismatched id → `mismatch_cnt`+1, stay in WAIT_RESP.
  - `sync_vld` aborts → WAIT_FUP, pulse `cap_t2` (no count).
- DONE: pulse `calc_start` → IDLE unconditionally.
- Timeout:
  - The counter reloads to 0 on every entry to WAIT_FUP or WAIT_RESP.
  - Reaching `TIMEOUT_CYC`-1 without the awaited event → IDLE, `timeout_cnt`+1.
- `enable`=0 in WAIT_FUP or WAIT_RESP → IDLE next cycle, no count. In TX_REQ/TX_WAIT the frame completes first, then the FSM proceeds normally.
- Both counters saturate at 255 and clear only on reset.

## Timing
- All outputs are registered. Strobes and state changes appear the cycle after the triggering input is sampled.
- Strobes are exactly one cycle wide. At most one strobe per cycle.
- `calc_start` fires one cycle after `cap_t4`. End-to-end minimum from `sync_vld` to `calc_start` is 6 cycles, given immediate ack/done/resp.
- Simultaneous events:
  - `fup_vld` and `sync_vld` in WAIT_FUP: Sync wins (restart).
  - `resp_vld` (match) and `sync_vld` in WAIT_RESP: the response wins, then the Sync is dropped.
  - An event and the timeout on the same cycle: the event wins.
- `tx_ack` high in the same cycle `tx_req` first rises is valid only from the cycle after; the ack is sampled while `tx_req`=1.
- Reset values:
  - state=IDLE
  - `tx_req`=0
  - `seq_id`=0
  - all strobes=0
  - `busy`=0
  - both counters=0
  - timeout counter=0
- `rst` mid-exchange forces these values on the next edge; any pending `tx_req` is dropped.

## Structure
- Shared package `ptp_pkg` holds:
  - the state encodings;
  - PTP messageType constants (Sync 16'h8002, Follow_Up 16'h8802, Delay_Resp 16'h8902, Delay_Req 16'h8102);
  - the default `TIMEOUT_CYC`.
- Sub-module `ptp_timeout_cnt`: loadable up-counter with `clr`/`en` inputs and a one-cycle `expire` output.

## Test plan
- Nominal: `sync_vld`@10, `fup_vld`@20, `tx_ack`@25, `tx_done`@40, `resp_vld`@50 with id 0x0001 → strobes t2@11, t1@21, t3@26, t4@51; `calc_start`@52; `seq_id`=0x0001.
- Wrap: `seq_id` preset to 0xFFFF by running 65535 exchanges (or a force), then one exchange → Delay_Req `seq_id`=0x0000 and a Delay_Resp with id 0x0000 is accepted.
- Mismatch: `resp_seqid`=0x0005 while `seq_id`=0x0004 → `mismatch_cnt`=1, no `cap_t4`; a following 0x0004 response → `calc_start`.
- Timeout: with `TIMEOUT_CYC`=100, a Sync and no Follow_Up → IDLE exactly 100 cycles after WAIT_FUP entry, `timeout_cnt`=1; 300 timeouts → `timeout_cnt`=255.
- Restart/priority: Sync during WAIT_RESP → WAIT_FUP with `cap_t2`; Sync and Follow_Up on the same cycle → `cap_t2` only.
- Reset mid-TX_REQ: `rst` held 1 cycle → `tx_req`=0, IDLE, `seq_id`=0 next edge; a late `tx_ack`/`tx_done` is ignored.
